// File: rtl/demux_sched_pkg.sv
// ============================================================================
// Module  : demux_sched_pkg
// Brief   : Shared types, constants and round-robin helper for demux_stream_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

package demux_sched_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef enum logic {MODE_ADDR = 1'b0, MODE_RR = 1'b1} mode_e;
  typedef logic [SEL_W-1:0] sel_t;

  // First free slot at or after ptr (mod N_OUT); scanning downward lets the
  // smallest offset overwrite the result last. Returns ptr when none free.
  function automatic sel_t rr_pick(input logic [N_OUT-1:0] free, input sel_t ptr);
    sel_t idx;
    rr_pick = ptr;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      idx = ptr + sel_t'(i);
      if (free[idx]) rr_pick = idx;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module  : demux_slot
// Brief   : One-entry valid/data holding register with load and drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Load wins over drain so a slot can empty and refill in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= load_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign free      = !r_valid || out_ready;

endmodule

`default_nettype wire

// File: rtl/demux_stream_sched.sv
// ============================================================================
// Module  : demux_stream_sched
// Brief   : Flow-controlled 1-to-4 stream dispatcher, addressed or round-robin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module demux_stream_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT*CNT_W-1:0]  out_cnt,
  output logic                    busy
);

  logic [N_OUT-1:0] w_free;
  logic [N_OUT-1:0] w_valid;
  logic [N_OUT-1:0] w_load;
  sel_t             w_rr_tgt;
  sel_t             w_tgt;
  logic             w_slot_rdy;
  logic             w_accept;
  sel_t             r_rr_ptr;

  assign w_rr_tgt = rr_pick(w_free, r_rr_ptr);

  // in_ready depends only on slot state, mode, in_sel and the pointer.
  always_comb begin
    w_tgt      = in_sel;
    w_slot_rdy = w_free[in_sel];
    if (mode_e'(mode) == MODE_RR) begin
      w_tgt      = w_rr_tgt;
      w_slot_rdy = |w_free;
    end
  end

  assign in_ready = !rst && w_slot_rdy;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept && (mode_e'(mode) == MODE_RR)) begin
      r_rr_ptr <= w_tgt + sel_t'(1);
    end
  end

  generate
    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
      logic [CNT_W-1:0] r_cnt;

      assign w_load[k] = w_accept && (w_tgt == sel_t'(k));

      demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load[k]),
        .load_data (in_data),
        .out_ready (out_ready[k]),
        .out_valid (w_valid[k]),
        .out_data  (out_data[k*DATA_W +: DATA_W]),
        .free      (w_free[k])
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_valid[k] && out_ready[k]) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign out_cnt[k*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign out_valid = w_valid;
  assign busy      = |w_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux_stream_sched.sv
// ============================================================================
// Module  : tb_demux_stream_sched
// Brief   : Directed self-checking bench for demux_stream_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demux_stream_sched;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [31:0] out_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  demux_stream_sched #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  initial begin
    // Reset held two cycles with a beat offered.
    rst = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'd0;
    out_ready = 4'hF;
    #1;
    chk("rst_rdy0", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", out_cnt, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Addressed, all consumers ready.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i); in_data = 8'(8'hA0 + i); in_valid = 1'b1;
      #1;
      chk("addr_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("addr_valid", 32'(out_valid), 32'(4'b0001 << i));
      chk("addr_data", 32'(out_data[i*8 +: 8]), 32'(8'hA0 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("addr_cnt", out_cnt, 32'h01010101);
    chk("addr_idle", 32'(out_valid), 32'd0);

    // Addressed, ch2 stalled: head-of-line blocking.
    out_ready = 4'b1011; in_sel = 2'd2; in_data = 8'h55; in_valid = 1'b1;
    #1;
    chk("hol_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h56;
    #1;
    chk("hol_rdy2", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("hol_hold_data", 32'(out_data[23:16]), 32'h55);
    chk("hol_hold_valid", 32'(out_valid), 32'b0100);
    chk("hol_rdy3", 32'(in_ready), 32'd0);
    out_ready = 4'hF;
    #1;
    chk("hol_rdy4", 32'(in_ready), 32'd1);
    tick();
    chk("hol_refill_data", 32'(out_data[23:16]), 32'h56);
    chk("hol_refill_valid", 32'(out_valid), 32'b0100);
    chk("hol_cnt2", 32'(out_cnt[23:16]), 32'd2);
    in_valid = 1'b0;
    tick();
    chk("hol_cnt", out_cnt, 32'h01030101);

    // Round-robin, all ready: 0,1,2,3,0,1.
    mode = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'h10 + i); in_valid = 1'b1;
      #1;
      chk("rr_rdy", 32'(in_ready), 32'd1);
      tick();
      chk("rr_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      chk("rr_data", 32'(out_data[(i % 4)*8 +: 8]), 32'(8'h10 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("rr_cnt", out_cnt, 32'h02040303);

    // Round-robin with ch2 stalled: pointer resumes at 2, then ch2 is skipped.
    out_ready = 4'b1011;
    in_data = 8'h20; in_valid = 1'b1;
    tick();
    chk("rrs_ptr2", 32'(out_valid), 32'b0100);
    in_data = 8'h21; tick();
    chk("rrs_v21", 32'(out_valid), 32'b1100);
    in_data = 8'h22; tick();
    chk("rrs_v22", 32'(out_valid), 32'b0101);
    in_data = 8'h23; tick();
    chk("rrs_v23", 32'(out_valid), 32'b0110);
    in_data = 8'h24; tick();
    chk("rrs_skip2", 32'(out_valid), 32'b1100);
    chk("rrs_d24", 32'(out_data[31:24]), 32'h24);
    out_ready = 4'b0000;
    in_data = 8'h25; tick();
    in_data = 8'h26; tick();
    chk("full_valid", 32'(out_valid), 32'hF);
    chk("full_data", out_data, 32'h24202625);
    chk("full_rdy_rr", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    mode = 1'b0; in_sel = 2'd0;
    #1;
    chk("full_rdy_addr", 32'(in_ready), 32'd0);

    // Reset mid-stream with ch1 holding 0x77.
    out_ready = 4'hF; in_sel = 2'd1; in_data = 8'h77; in_valid = 1'b1;
    tick();
    out_ready = 4'h0; in_valid = 1'b0;
    #1;
    chk("mid_hold", 32'(out_data[15:8]), 32'h77);
    chk("mid_hold_valid", 32'(out_valid), 32'b0010);
    rst = 1'b1; mode = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt", out_cnt, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    rst = 1'b0; out_ready = 4'hF; in_data = 8'h88;
    tick();
    chk("mid_rr_ch0", 32'(out_valid), 32'b0001);
    chk("mid_rr_data", 32'(out_data[7:0]), 32'h88);
    in_valid = 1'b0;
    tick();
    chk("mid_cnt", out_cnt, 32'h00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
